alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that performs 32-bit MUL, DIVU and REMU by driving the shared single-cycle ALU one operation per cycle.
- Sits beside the execute stage. Owns the ALU operand and select inputs while busy, and returns a registered result with a one-cycle done pulse.
- Uses only the existing ALU encodings `ADD, `SUB and `SLTU from the shared ALU defines include. Shifts by one are local wiring.

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.
- SEL_W, 4, width of the ALU select bus.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  2  operation: 00 = MUL (low 32 bits), 01 = DIVU, 10 = REMU, 11 = reserved.
- src_a  input  XLEN  multiplicand or dividend.
- src_b  input  XLEN  multiplier or divisor.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  XLEN  registered result; held until the next done.
- alu_rs1  output  XLEN  ALU operand 1.
- alu_rs2  output  XLEN  ALU operand 2.
- alu_sel  output  SEL_W  ALU operation select.
- alu_res  input  XLEN  ALU combinational result, same cycle.

Behaviour:
- Clock and reset: one clock (clock). reset is synchronous and active-low.
- Reset values: state = IDLE; busy = 0; done = 0; result = 0; cnt = 0; all internal registers = 0.
- Reset mid-operation aborts the operation: no done pulse, and result keeps its reset value 0.
- States: IDLE, MUL_STEP, DIV_CMP, DIV_SUB, DONE.
- ALU drive is combinational from state and registers. In IDLE and DONE: alu_rs1 = 0, alu_rs2 = 0, alu_sel = `ADD.

IDLE:
- If start=1: latch operands and op, then go to:
  - MUL_STEP with acc=0, mcand=src_a, mplier=src_b, cnt=0 when op=00;
  - DIV_CMP with rem=0, quo=src_a, dvs=src_b, cnt=0 when op=01 or 10;
  - DONE with the special result when op=11 or divisor=0.
- Special results:
  - op=11 gives result 0.
  - DIVU by 0 gives 0xFFFFFFFF.
  - REMU by 0 gives src_a.

MUL_STEP (one iteration per cycle):
- alu_rs1 = acc, alu_rs2 = mcand, alu_sel = `ADD.
- If mplier[0]=1 then acc <= alu_res.
- mcand <= mcand<<1; mplier <= mplier>>1; cnt++.
- After the 32nd step: result <= the final acc, go to DONE.
- Arithmetic wraps modulo 2^32.

DIV_CMP:
- rs = {rem[30:0], quo[31]}; carry = rem[31].
- alu_rs1 = rs, alu_rs2 = dvs, alu_sel = `SLTU.
- ge <= carry | ~alu_res[0]; rem <= rs; quo <= quo<<1. Go to DIV_SUB.

DIV_SUB:
- alu_rs1 = rem, alu_rs2 = dvs, alu_sel = `SUB.
- If ge: rem <= alu_res and quo[0] <= 1.
- cnt++. If cnt reaches 32, result <= quo (DIVU) or the final rem (REMU) and go to DONE; otherwise return to DIV_CMP.
- The 32-bit wrap of the SUB is correct when carry=1.

DONE:
- done=1 and busy=0 for exactly one cycle, then IDLE.
- start in DONE is ignored; a new start is accepted from the following IDLE cycle.

Latency (start accepted at edge T):
- busy=1 from T+1.
- MUL: done at cycle T+33.
- DIVU/REMU: done at T+65.
- Divide-by-zero and reserved op: done at T+1, busy stays 0.

Boundary conditions:
- start while busy or in DONE is ignored; operands are not re-latched.
- src_a/src_b may change after acceptance without effect.
- alu_res is consumed only in MUL_STEP, DIV_CMP and DIV_SUB.

Test Plan:
- MUL 6 x 7: start at T → busy 1 from T+1; done at T+33 with result 0x0000002A; exactly one ALU `ADD per busy cycle.
- MUL 0xFFFFFFFF x 0xFFFFFFFF → result 0x00000001. MUL 0x00010000 x 0x00010000 → result 0x00000000 (wrap).
- DIVU 100/7 → 0x0000000E at T+65. REMU 100/7 → 0x00000002. alu_sel alternates `SLTU/`SUB for 64 cycles.
- Carry path: DIVU 0xFFFFFFFF/0x80000001 → 0x00000001; REMU with the same operands → 0x7FFFFFFE.
- Divide by zero and reserved op:
  - DIVU 5/0 → done at T+1, result 0xFFFFFFFF.
  - REMU 5/0 → result 0x00000005.
  - op=11 → result 0; busy never asserted.
- Control:
  - start pulsed again mid-MUL with new operands → ignored; original result still returned.
  - reset=0 at step 10 of a DIVU → next cycle IDLE, busy 0, done never pulses, result 0.
  - Back-to-back: new start one cycle after done → accepted and completes correctly.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MUL / DIVU / REMU sequencer that borrows the shared single-cycle ALU,
// issuing one ADD, SUB or SLTU per cycle and returning a registered result with a done pulse.
`ifndef ADD
`define ADD 4'b0000
`endif
`ifndef SUB
`define SUB 4'b1000
`endif
`ifndef SLTU
`define SLTU 4'b0011
`endif

module alu_muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int SEL_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [XLEN-1:0]  src_a,
    input  logic [XLEN-1:0]  src_b,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [XLEN-1:0]  alu_rs1,
    output logic [XLEN-1:0]  alu_rs2,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [XLEN-1:0]  alu_res
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MUL_STEP = 3'd1;
    localparam logic [2:0] S_DIV_CMP  = 3'd2;
    localparam logic [2:0] S_DIV_SUB  = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;

    localparam int               CNT_W    = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [SEL_W-1:0] SEL_ADD  = SEL_W'(`ADD);
    localparam logic [SEL_W-1:0] SEL_SUB  = SEL_W'(`SUB);
    localparam logic [SEL_W-1:0] SEL_SLTU = SEL_W'(`SLTU);

    logic [2:0]       state_r;
    logic             busy_r;
    logic             done_r;
    logic [XLEN-1:0]  result_r;
    logic [XLEN-1:0]  acc_r;
    logic [XLEN-1:0]  mcand_r;
    logic [XLEN-1:0]  mplier_r;
    logic [XLEN-1:0]  rem_r;
    logic [XLEN-1:0]  quo_r;
    logic [XLEN-1:0]  dvs_r;
    logic             ge_r;
    logic [1:0]       op_r;
    logic [CNT_W-1:0] cnt_r;

    logic [XLEN-1:0]  div_rs_s;
    logic [XLEN-1:0]  mul_acc_s;
    logic [XLEN-1:0]  sub_rem_s;
    logic [XLEN-1:0]  sub_quo_s;

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

    // Per-step next values for the multiply accumulate and the restoring-divide update
    always_comb begin
        div_rs_s = {rem_r[XLEN-2:0], quo_r[XLEN-1]};
        if (mplier_r[0]) begin
            mul_acc_s = alu_res;
        end else begin
            mul_acc_s = acc_r;
        end
        if (ge_r) begin
            sub_rem_s = alu_res;
            sub_quo_s = {quo_r[XLEN-1:1], 1'b1};
        end else begin
            sub_rem_s = rem_r;
            sub_quo_s = quo_r;
        end
    end

    // ALU operand and select drive, decoded from the current state
    always_comb begin
        alu_rs1 = {XLEN{1'b0}};
        alu_rs2 = {XLEN{1'b0}};
        alu_sel = SEL_ADD;
        case (state_r)
            S_MUL_STEP: begin
                alu_rs1 = acc_r;
                alu_rs2 = mcand_r;
                alu_sel = SEL_ADD;
            end
            S_DIV_CMP: begin
                alu_rs1 = div_rs_s;
                alu_rs2 = dvs_r;
                alu_sel = SEL_SLTU;
            end
            S_DIV_SUB: begin
                alu_rs1 = rem_r;
                alu_rs2 = dvs_r;
                alu_sel = SEL_SUB;
            end
            default: begin
                alu_rs1 = {XLEN{1'b0}};
                alu_rs2 = {XLEN{1'b0}};
                alu_sel = SEL_ADD;
            end
        endcase
    end

    // Sequencer state, datapath registers and registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r  <= S_IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {XLEN{1'b0}};
            acc_r    <= {XLEN{1'b0}};
            mcand_r  <= {XLEN{1'b0}};
            mplier_r <= {XLEN{1'b0}};
            rem_r    <= {XLEN{1'b0}};
            quo_r    <= {XLEN{1'b0}};
            dvs_r    <= {XLEN{1'b0}};
            ge_r     <= 1'b0;
            op_r     <= 2'b00;
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        cnt_r <= {CNT_W{1'b0}};
                        if (op == OP_MUL) begin
                            acc_r    <= {XLEN{1'b0}};
                            mcand_r  <= src_a;
                            mplier_r <= src_b;
                            busy_r   <= 1'b1;
                            state_r  <= S_MUL_STEP;
                        end else if ((op == OP_DIVU || op == OP_REMU) && src_b != {XLEN{1'b0}}) begin
                            rem_r   <= {XLEN{1'b0}};
                            quo_r   <= src_a;
                            dvs_r   <= src_b;
                            busy_r  <= 1'b1;
                            state_r <= S_DIV_CMP;
                        end else begin
                            // Zero divisor and reserved op finish immediately with a fixed result
                            if (op == OP_DIVU) begin
                                result_r <= {XLEN{1'b1}};
                            end else if (op == OP_REMU) begin
                                result_r <= src_a;
                            end else begin
                                result_r <= {XLEN{1'b0}};
                            end
                            done_r  <= 1'b1;
                            state_r <= S_DONE;
                        end
                    end
                end
                S_MUL_STEP: begin
                    acc_r    <= mul_acc_s;
                    mcand_r  <= {mcand_r[XLEN-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
                    cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_LAST) begin
                        result_r <= mul_acc_s;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        state_r  <= S_DONE;
                    end
                end
                S_DIV_CMP: begin
                    // A shifted-out remainder MSB means rs >= 2^XLEN > dvs regardless of SLTU
                    ge_r    <= rem_r[XLEN-1] | ~alu_res[0];
                    rem_r   <= div_rs_s;
                    quo_r   <= {quo_r[XLEN-2:0], 1'b0};
                    state_r <= S_DIV_SUB;
                end
                S_DIV_SUB: begin
                    rem_r <= sub_rem_s;
                    quo_r <= sub_quo_s;
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_LAST) begin
                        if (op_r == OP_REMU) begin
                            result_r <= sub_rem_s;
                        end else begin
                            result_r <= sub_quo_s;
                        end
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        state_r <= S_DIV_CMP;
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomised self-checking bench for alu_muldiv_seq: plain-arithmetic reference model,
// per-cycle compare of busy/done/result/ALU drive, plus hand-computed directed cases.
`ifndef ADD
`define ADD 4'b0000
`endif
`ifndef SUB
`define SUB 4'b1000
`endif
`ifndef SLTU
`define SLTU 4'b0011
`endif

module tb_alu_muldiv_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] alu_rs1;
    logic [31:0] alu_rs2;
    logic [3:0]  alu_sel;
    logic [31:0] alu_res;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    // reference model state
    bit          m_busy   = 0;
    bit          m_done   = 0;
    bit          m_is_mul = 0;
    int          m_left   = 0;
    logic [31:0] m_result = 32'h0;
    logic [31:0] m_pend   = 32'h0;

    alu_muldiv_seq #(.XLEN(32), .SEL_W(4)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
        .result(result), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_sel(alu_sel), .alu_res(alu_res)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // stand-in for the shared single-cycle ALU
    always_comb begin
        case (alu_sel)
            `ADD:    alu_res = alu_rs1 + alu_rs2;
            `SUB:    alu_res = alu_rs1 - alu_rs2;
            `SLTU:   alu_res = {31'b0, alu_rs1 < alu_rs2};
            default: alu_res = 32'h0;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void ref_calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output int lat);
        case (o)
            2'b00: begin r = a * b; lat = 33; end
            2'b01: begin
                if (b == 32'h0) begin r = 32'hFFFF_FFFF; lat = 1; end
                else begin r = a / b; lat = 65; end
            end
            2'b10: begin
                if (b == 32'h0) begin r = a; lat = 1; end
                else begin r = a % b; lat = 65; end
            end
            default: begin r = 32'h0; lat = 1; end
        endcase
    endfunction

    // transaction-level model: counts down the latency of the accepted request
    always @(posedge clock) begin
        logic [31:0] r;
        int lat;
        if (!reset) begin
            m_busy = 0; m_done = 0; m_left = 0; m_result = 32'h0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0; m_done = 1; m_result = m_pend;
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (start) begin
            ref_calc(op, src_a, src_b, r, lat);
            m_is_mul = (op == 2'b00);
            if (lat == 1) begin
                m_done = 1; m_result = r;
            end else begin
                m_busy = 1; m_left = lat - 1; m_pend = r;
            end
        end
    end

    // per-cycle compare against the model
    always @(negedge clock) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("result", result, m_result);
            if (m_busy && m_is_mul) begin
                chk("alu_sel_mul", 32'(alu_sel), 32'(`ADD));
            end else if (m_busy) begin
                chk("alu_sel_div", 32'(alu_sel), (m_left % 2 == 0) ? 32'(`SLTU) : 32'(`SUB));
            end else begin
                chk("alu_sel_idle", 32'(alu_sel), 32'(`ADD));
                chk("alu_rs1_idle", alu_rs1, 32'h0);
                chk("alu_rs2_idle", alu_rs2, 32'h0);
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input int exp_lat, input int spur, input string nm);
        int lat;
        @(negedge clock);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clock);
        start = 1'b0; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            start = (lat == spur);
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_result"}, result, exp_r);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  o;
        int lat;
        reset = 1'b0; start = 1'b0; op = 2'b00; src_a = 32'h0; src_b = 32'h0;
        repeat (3) @(negedge clock);
        chk_en = 1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_result", result, 32'h0);
        reset = 1'b1;

        run_op(2'b00, 32'd6, 32'd7, 32'h0000_002A, 33, 0, "mul_6x7");
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 0, "mul_ones");
        run_op(2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33, 0, "mul_wrap");
        run_op(2'b01, 32'd100, 32'd7, 32'h0000_000E, 65, 0, "divu_100_7");
        run_op(2'b10, 32'd100, 32'd7, 32'h0000_0002, 65, 0, "remu_100_7");
        run_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001, 65, 0, "divu_carry");
        run_op(2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 65, 0, "remu_carry");
        run_op(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, "divu_by0");
        run_op(2'b10, 32'd5, 32'd0, 32'h0000_0005, 1, 0, "remu_by0");
        run_op(2'b11, 32'd9, 32'd3, 32'h0000_0000, 1, 0, "reserved");
        run_op(2'b00, 32'd6, 32'd7, 32'h0000_002A, 33, 10, "mul_restart_ignored");

        // start raised during DONE must be ignored; the following IDLE start is back-to-back
        start = 1'b1; op = 2'b00; src_a = 32'd3; src_b = 32'd3;
        run_op(2'b01, 32'd1000, 32'd10, 32'd100, 65, 0, "divu_after_done");

        // abort a divide part-way through with reset
        @(negedge clock);
        start = 1'b1; op = 2'b01; src_a = 32'd100; src_b = 32'd7;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_result", result, 32'h0);
        repeat (70) @(negedge clock);

        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 255));
            ref_calc(o, a, b, r, lat);
            repeat ($urandom_range(0, 2)) @(negedge clock);
            run_op(o, a, b, r, lat, int'($urandom_range(0, 80)), "random");
        end

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
